ram_loader: RTL and testbench

Streaming initiator for the NBBPU data RAM port. It loads 16-bit words into RAM from an 8-bit byte stream, or dumps RAM words back out as an 8-bit byte stream. It drives the RAM's write_enable/address/write_data inputs and consumes its combinational read_data. It sits between the host serial link (UART byte interface) and the RAM, and is used for program/data upload and memory readback while the CPU is held off the port.

---
 rtl/ram_loader_if.sv | 42 ++++
 rtl/ram_loader.sv | 130 +++++++++++++
 tb/tb_ram_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_if.sv
// Bundle of host control, byte-stream and RAM-port signals for ram_loader.
// Signal suffixes are from the loader's point of view; the loader binds the slave modport.
interface ram_loader_if;
  localparam int unsigned AddrW  = 16;
  localparam int unsigned WordW  = 16;
  localparam int unsigned ByteW  = 8;
  localparam int unsigned CountW = 9;

  logic              start_i;
  logic              mode_i;
  logic [AddrW-1:0]  base_address_i;
  logic [CountW-1:0] word_count_i;
  logic              busy_o;
  logic              done_o;

  logic [ByteW-1:0]  rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;

  logic [ByteW-1:0]  tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;

  logic              ram_write_enable_o;
  logic [AddrW-1:0]  ram_address_o;
  logic [WordW-1:0]  ram_write_data_o;
  logic [WordW-1:0]  ram_read_data_i;

  modport slave (
    input  start_i, mode_i, base_address_i, word_count_i,
    input  rx_data_i, rx_valid_i, tx_ready_i, ram_read_data_i,
    output busy_o, done_o, rx_ready_o, tx_data_o, tx_valid_o,
    output ram_write_enable_o, ram_address_o, ram_write_data_o
  );

  modport master (
    output start_i, mode_i, base_address_i, word_count_i,
    output rx_data_i, rx_valid_i, tx_ready_i, ram_read_data_i,
    input  busy_o, done_o, rx_ready_o, tx_data_o, tx_valid_o,
    input  ram_write_enable_o, ram_address_o, ram_write_data_o
  );
endinterface

// File: rtl/ram_loader.sv
// Byte-stream to RAM word loader / RAM word to byte-stream dumper, little-endian.
// Every output is a register loaded from next-state values, so no input reaches an output combinationally.
module ram_loader #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_loader_if.slave  bus
);
  localparam int unsigned AddrW  = 16;
  localparam int unsigned WordW  = 16;
  localparam int unsigned ByteW  = 8;
  localparam int unsigned CountW = 9;

  typedef enum logic [2:0] {
    IDLE, LOAD_LO, LOAD_HI, WRITE, DUMP_READ, DUMP_LO, DUMP_HI, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [AddrW-1:0]  ptr_q, ptr_d;
  logic [CountW-1:0] rem_q, rem_d;
  logic [WordW-1:0]  data_q, data_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rx_ready_q, rx_ready_d;
  logic             tx_valid_q, tx_valid_d;
  logic             we_q, we_d;
  logic [ByteW-1:0] tx_data_q, tx_data_d;

  // Next state, datapath and the output values that the next state will present.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          ptr_d = {bus.base_address_i[AddrW-1:1], 1'b0};
          rem_d = bus.word_count_i;
          if (bus.word_count_i == CountW'(0)) state_d = DONE;
          else if (bus.mode_i)                state_d = DUMP_READ;
          else                                state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (bus.rx_valid_i) begin
          data_d[ByteW-1:0] = bus.rx_data_i;
          state_d           = LOAD_HI;
        end
      end
      LOAD_HI: begin
        if (bus.rx_valid_i) begin
          data_d[WordW-1:ByteW] = bus.rx_data_i;
          state_d               = WRITE;
        end
      end
      WRITE: begin
        ptr_d   = ptr_q + AddrW'(2);
        rem_d   = rem_q - CountW'(1);
        state_d = (rem_q == CountW'(1)) ? DONE : LOAD_LO;
      end
      DUMP_READ: begin
        data_d  = bus.ram_read_data_i;
        state_d = DUMP_LO;
      end
      DUMP_LO: begin
        if (bus.tx_ready_i) state_d = DUMP_HI;
      end
      DUMP_HI: begin
        if (bus.tx_ready_i) begin
          ptr_d   = ptr_q + AddrW'(2);
          rem_d   = rem_q - CountW'(1);
          state_d = (rem_q == CountW'(1)) ? DONE : DUMP_READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    rx_ready_d = (state_d == LOAD_LO) || (state_d == LOAD_HI);
    tx_valid_d = (state_d == DUMP_LO) || (state_d == DUMP_HI);
    we_d       = (state_d == WRITE);
    tx_data_d  = (state_d == DUMP_HI) ? data_d[WordW-1:ByteW] : data_d[ByteW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      we_q       <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      we_q       <= we_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.busy_o             = busy_q;
  assign bus.done_o             = done_q;
  assign bus.rx_ready_o         = rx_ready_q;
  assign bus.tx_valid_o         = tx_valid_q;
  assign bus.tx_data_o          = tx_data_q;
  assign bus.ram_write_enable_o = we_q;
  assign bus.ram_address_o      = ptr_q;
  assign bus.ram_write_data_o   = data_q;

  // A requested transfer must fit the attached RAM.
  a_count_fits: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE && bus.start_i) |-> (32'(bus.word_count_i) <= DEPTH_WORDS));

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: directed vector table, reset corner case and random transfers,
// all checked against a word-level reference model of RAM contents and byte streams.
module tb_ram_loader;
  localparam int BUDGET = 4000;

  typedef struct {
    logic        mode;
    logic [15:0] base;
    int          count;
    int          gap_max;
    int          txp;       // 0 held ready, 1 toggling, 2 random
    bit          poke;
    int          exp_done;  // -1: not checked
  } vec_t;

  logic clk;
  logic rst_n;
  ram_loader_if bus ();

  ram_loader #(.DEPTH_WORDS(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [15:0] ram     [32768];
  logic [15:0] ref_mem [32768];
  logic [15:0] act_w_addr[$], act_w_data[$], exp_w_addr[$], exp_w_data[$];
  int          act_w_cyc[$];
  logic [7:0]  act_tx[$], exp_tx[$], rx_bytes[$];
  int          cyc;
  int          n_cmp;
  int          n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ram_read_data_i = ram[bus.ram_address_o[15:1]];

  // Behavioural RAM plus logs of every write and every tx handshake.
  always @(posedge clk) begin
    if (bus.ram_write_enable_o) begin
      act_w_addr.push_back(bus.ram_address_o);
      act_w_data.push_back(bus.ram_write_data_o);
      act_w_cyc.push_back(cyc);
      ram[bus.ram_address_o[15:1]] = bus.ram_write_data_o;
    end
    if (bus.tx_valid_o && bus.tx_ready_i) act_tx.push_back(bus.tx_data_o);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {bus.busy_o, bus.done_o, bus.rx_ready_o, bus.tx_valid_o, bus.ram_write_enable_o,
                 bus.tx_data_o, bus.ram_address_o, bus.ram_write_data_o}, 64'd0);
  endtask

  task automatic clear_logs();
    act_w_addr.delete(); act_w_data.delete(); act_w_cyc.delete(); act_tx.delete();
    exp_w_addr.delete(); exp_w_data.delete(); exp_tx.delete(); rx_bytes.delete();
  endtask

  task automatic do_xfer(input logic mode, input logic [15:0] base, input int count, input int gap_max,
                         input int txp, input bit poke, output int done_cyc);
    logic [15:0] ptr;
    logic [15:0] w;
    logic [7:0]  prev_data;
    int          gap;
    bit          got, prev_stall, seen_rx, seen_tx;

    clear_logs();
    ptr = {base[15:1], 1'b0};
    for (int i = 0; i < count; i++) begin
      if (!mode) begin
        w = 16'($urandom);
        rx_bytes.push_back(w[7:0]);
        rx_bytes.push_back(w[15:8]);
        exp_w_addr.push_back(ptr);
        exp_w_data.push_back(w);
        ref_mem[ptr[15:1]] = w;
      end else begin
        w = ref_mem[ptr[15:1]];
        exp_tx.push_back(w[7:0]);
        exp_tx.push_back(w[15:8]);
      end
      ptr = ptr + 16'd2;
    end

    bus.start_i        = 1'b1;
    bus.mode_i         = mode;
    bus.base_address_i = base;
    bus.word_count_i   = 9'(count);
    @(negedge clk);
    cyc = 1;
    bus.start_i = 1'b0;
    gap = 0; got = 0; prev_stall = 0; seen_rx = 0; seen_tx = 0; prev_data = 8'd0;
    done_cyc = -1;

    while (cyc <= BUDGET) begin
      if (prev_stall) begin
        check("tx_hold_valid", 64'(bus.tx_valid_o), 64'd1);
        check("tx_hold_data", 64'(bus.tx_data_o), 64'(prev_data));
      end
      if (bus.rx_ready_o) seen_rx = 1;
      if (bus.tx_valid_o) seen_tx = 1;
      if (bus.done_o) begin
        got = 1;
        done_cyc = cyc;
        break;
      end

      bus.start_i = poke && (cyc == 4);
      if (bus.start_i) begin
        bus.mode_i         = 1'($urandom_range(1, 0));
        bus.base_address_i = 16'($urandom);
        bus.word_count_i   = 9'($urandom_range(256, 0));
      end

      if (gap > 0) begin
        bus.rx_valid_i = 1'b0;
        gap--;
      end else if (rx_bytes.size() > 0) begin
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = rx_bytes[0];
        if (bus.rx_ready_o) begin
          void'(rx_bytes.pop_front());
          gap = $urandom_range(gap_max, 0);
        end
      end else begin
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'($urandom);
      end

      case (txp)
        0:       bus.tx_ready_i = 1'b1;
        1:       bus.tx_ready_i = ((cyc % 2) == 1);
        default: bus.tx_ready_i = 1'($urandom_range(1, 0));
      endcase
      prev_stall = bus.tx_valid_o && !bus.tx_ready_i;
      prev_data  = bus.tx_data_o;

      @(negedge clk);
      cyc++;
    end

    bus.start_i    = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b0;

    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles (mode %0d count %0d)", BUDGET, mode, count);
    end else begin
      check("busy_at_done", 64'(bus.busy_o), 64'd1);
      @(negedge clk);
      check("idle_after_done", {62'd0, bus.busy_o, bus.done_o}, 64'd0);
    end

    if (count == 0 || mode)  check("no_rx_ready", 64'(seen_rx), 64'd0);
    if (count == 0 || !mode) check("no_tx_valid", 64'(seen_tx), 64'd0);

    check("wr_count", 64'(act_w_addr.size()), 64'(exp_w_addr.size()));
    for (int i = 0; i < act_w_addr.size() && i < exp_w_addr.size(); i++) begin
      check("wr_addr", 64'(act_w_addr[i]), 64'(exp_w_addr[i]));
      check("wr_data", 64'(act_w_data[i]), 64'(exp_w_data[i]));
      if (gap_max == 0) check("wr_cycle", 64'(act_w_cyc[i]), 64'(3 * i + 3));
    end
    check("tx_count", 64'(act_tx.size()), 64'(exp_tx.size()));
    for (int i = 0; i < act_tx.size() && i < exp_tx.size(); i++)
      check("tx_byte", 64'(act_tx[i]), 64'(exp_tx[i]));
  endtask

  vec_t vecs[12];
  int   d;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.base_address_i = 16'd0; bus.word_count_i = 9'd0;
    bus.rx_data_i = 8'd0; bus.rx_valid_i = 1'b0; bus.tx_ready_i = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      ram[i]     = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[8] = 16'hBEEF; ref_mem[8] = 16'hBEEF;
    ram[9] = 16'hCAFE; ref_mem[9] = 16'hCAFE;

    vecs[0]  = '{1'b1, 16'h0011,   2, 0, 1, 1'b0, -1};
    vecs[1]  = '{1'b0, 16'h0010,   2, 0, 0, 1'b0,  7};
    vecs[2]  = '{1'b0, 16'h0100,   4, 5, 0, 1'b0, -1};
    vecs[3]  = '{1'b0, 16'h0020,   0, 0, 0, 1'b0,  1};
    vecs[4]  = '{1'b1, 16'h0020,   0, 0, 0, 1'b0,  1};
    vecs[5]  = '{1'b0, 16'h0200,   3, 0, 0, 1'b1, 10};
    vecs[6]  = '{1'b0, 16'hFFFE,   2, 0, 0, 1'b0,  7};
    vecs[7]  = '{1'b1, 16'hFFFF,   2, 0, 0, 1'b0,  7};
    vecs[8]  = '{1'b0, 16'h0000, 256, 0, 0, 1'b0, 769};
    vecs[9]  = '{1'b1, 16'h0000, 256, 0, 0, 1'b0, 769};
    vecs[10] = '{1'b1, 16'h0301,   5, 0, 2, 1'b0, -1};
    vecs[11] = '{1'b0, 16'h0401,   5, 3, 2, 1'b1, -1};

    #2;
    check_outputs_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("idle_after_reset");

    for (int i = 0; i < 12; i++) begin
      do_xfer(vecs[i].mode, vecs[i].base, vecs[i].count, vecs[i].gap_max, vecs[i].txp, vecs[i].poke, d);
      if (vecs[i].exp_done >= 0) check("done_cycle", 64'(d), 64'(vecs[i].exp_done));
      if (i == 0) begin
        check("dump_bytes", {32'd0, act_tx.size() == 4 ? {act_tx[0], act_tx[1], act_tx[2], act_tx[3]} : 32'd0},
              64'hEFBEFECA);
      end
    end

    // Reset after the low byte of a load: no write, and the next word uses fresh bytes.
    clear_logs();
    bus.start_i = 1'b1; bus.mode_i = 1'b0; bus.base_address_i = 16'h0500; bus.word_count_i = 9'd1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.rx_valid_i = 1'b1; bus.rx_data_i = 8'hAA;
    @(negedge clk);
    bus.rx_data_i = 8'hBB;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("outputs_in_reset");
    bus.rx_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("outputs_held_reset");
    check("reset_no_write", 64'(act_w_addr.size()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_xfer(1'b0, 16'h0500, 1, 0, 0, 1'b0, d);
    check("done_after_reset", 64'(d), 64'd4);

    for (int r = 0; r < 24; r++) begin
      logic        m;
      logic [15:0] b;
      int          c, g, t;
      bit          p;
      m = 1'($urandom_range(1, 0));
      b = 16'($urandom);
      c = $urandom_range(12, 0);
      g = $urandom_range(3, 0);
      t = $urandom_range(2, 0);
      p = (c >= 2) && ($urandom_range(1, 0) == 1);
      do_xfer(m, b, c, g, t, p, d);
      if (g == 0 && t == 0) check("rand_done_cycle", 64'(d), 64'((c == 0) ? 1 : 3 * c + 1));
    end

    begin
      int diffs;
      diffs = 0;
      for (int i = 0; i < 32768; i++) if (ram[i] !== ref_mem[i]) diffs++;
      check("ram_image", 64'(diffs), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
